// File: rtl/cool_heat_pkg.sv
// Shared types and defaults for the cool/heat fan controller.
// Holds mode encodings, speed range and the default thresholds.
package cool_heat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_COOL = 2'b01,
    ST_HEAT = 2'b10
  } state_t;

  localparam int SPEED_W   = 8;
  localparam int SPEED_MAX = 255;

  localparam int D_COOL_ON   = 35;
  localparam int D_COOL_OFF  = 25;
  localparam int D_HEAT_ON   = 15;
  localparam int D_HEAT_OFF  = 20;
  localparam int D_GAIN      = 8;
  localparam int D_MIN_SPEED = 32;
  localparam int D_STEP      = 16;
  localparam int D_RAMP_DIV  = 4;

  function automatic logic [SPEED_W-1:0] sat8(
    input logic [15:0] v
  );
    return (v > 16'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                : v[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/cool_heat_controller_speed_ramp.sv
// Slew limiter: free-running tick divider, speed steps toward target.
// Ports: clk, rst (sync, high), target[7:0] in, speed[7:0] out.
module speed_ramp
  import cool_heat_pkg::*;
#(
  parameter int STEP     = D_STEP,
  parameter int RAMP_DIV = D_RAMP_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] target,
  output logic [SPEED_W-1:0] speed
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CW-1:0]      ramp_cnt;
  logic               tick;
  logic [SPEED_W:0]   up;
  logic [SPEED_W-1:0] gap;
  logic [SPEED_W-1:0] speed_nxt;

  assign tick = (ramp_cnt == CW'(RAMP_DIV - 1));
  assign up   = {1'b0, speed} + (SPEED_W+1)'(STEP);
  assign gap  = speed - target;

  always_comb begin
    speed_nxt = speed;
    unique case (1'b1)
      tick && (speed < target):
        speed_nxt = (up >= {1'b0, target}) ? target
                                           : up[SPEED_W-1:0];
      tick && (speed > target):
        speed_nxt = (gap <= SPEED_W'(STEP)) ? target
                                            : speed - SPEED_W'(STEP);
      default: speed_nxt = speed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_cnt <= '0;
      speed    <= '0;
    end else begin
      ramp_cnt <= tick ? '0 : ramp_cnt + CW'(1);
      speed    <= speed_nxt;
    end
  end

endmodule

// File: rtl/cool_heat_controller.sv
// Hysteretic cool/heat mode FSM with proportional fan target.
// Ports: clk, rst, temp[7:0], temp_valid -> speed, cooler_on, heater_on, state.
module cool_heat_controller
  import cool_heat_pkg::*;
#(
  parameter int COOL_ON   = D_COOL_ON,
  parameter int COOL_OFF  = D_COOL_OFF,
  parameter int HEAT_ON   = D_HEAT_ON,
  parameter int HEAT_OFF  = D_HEAT_OFF,
  parameter int GAIN      = D_GAIN,
  parameter int MIN_SPEED = D_MIN_SPEED,
  parameter int STEP      = D_STEP,
  parameter int RAMP_DIV  = D_RAMP_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         temp,
  input  logic               temp_valid,
  output logic [SPEED_W-1:0] speed,
  output logic               cooler_on,
  output logic               heater_on,
  output logic [1:0]         state
);

  state_t             st_q;
  state_t             st_nxt;
  logic [7:0]         temp_q;
  logic               seen;
  logic [7:0]         err;
  logic [15:0]        prod;
  logic [SPEED_W-1:0] sat;
  logic [SPEED_W-1:0] target;

  assign state = st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q <= '0;
      seen   <= 1'b0;
    end else if (temp_valid) begin
      temp_q <= temp;
      seen   <= 1'b1;
    end
  end

  always_comb begin
    st_nxt = st_q;
    if (seen) begin
      unique case (st_q)
        ST_IDLE: begin
          if (temp_q >= 8'(COOL_ON))
            st_nxt = ST_COOL;
          else if (temp_q <= 8'(HEAT_ON) && speed == '0)
            st_nxt = ST_HEAT;
        end
        ST_COOL:
          if (temp_q <= 8'(COOL_OFF)) st_nxt = ST_IDLE;
        ST_HEAT:
          if (temp_q >= 8'(HEAT_OFF)) st_nxt = ST_IDLE;
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cooler_on <= 1'b0;
      heater_on <= 1'b0;
    end else begin
      st_q      <= st_nxt;
      cooler_on <= (st_nxt == ST_COOL);
      heater_on <= (st_nxt == ST_HEAT);
    end
  end

  // Error saturates at zero: for one clock after a new sample crosses
  // the reference, state still shows the old mode and must not wrap.
  always_comb begin
    err = '0;
    unique case (st_q)
      ST_COOL:
        err = (temp_q > 8'(COOL_OFF)) ? temp_q - 8'(COOL_OFF) : '0;
      ST_HEAT:
        err = (temp_q < 8'(HEAT_OFF)) ? 8'(HEAT_OFF) - temp_q : '0;
      default: err = '0;
    endcase
  end

  assign prod = 16'(err) * 16'(GAIN);
  assign sat  = sat8(prod);

  always_comb begin
    target = '0;
    if (st_q != ST_IDLE)
      target = (sat < SPEED_W'(MIN_SPEED)) ? SPEED_W'(MIN_SPEED) : sat;
  end

  speed_ramp #(
    .STEP     (STEP),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk    (clk),
    .rst    (rst),
    .target (target),
    .speed  (speed)
  );

endmodule

// File: tb/tb_cool_heat_controller.sv
// Bench for cool_heat_controller: vector table, directed corners,
// and random stimulus against a behavioural reference model.
module tb_cool_heat_controller;

  logic       clk;
  logic       rst;
  logic [7:0] temp;
  logic       temp_valid;
  logic [7:0] speed;
  logic       cooler_on;
  logic       heater_on;
  logic [1:0] state;

  int n_chk;
  int n_fail;

  int m_st;
  int m_tq;
  int m_seen;
  int m_sp;
  int m_cyc;

  typedef struct {
    bit r;
    bit tv;
    int t;
    int st;
    int sp;
    bit co;
    bit he;
  } vec_t;

  vec_t vt[12];

  cool_heat_controller dut (
    .clk        (clk),
    .rst        (rst),
    .temp       (temp),
    .temp_valid (temp_valid),
    .speed      (speed),
    .cooler_on  (cooler_on),
    .heater_on  (heater_on),
    .state      (state)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_target(input int st, input int tq);
    int e;
    int p;
    if (st == 0) return 0;
    e = (st == 1) ? tq - 25 : 20 - tq;
    if (e < 0) e = 0;
    p = e * 8;
    if (p > 255) p = 255;
    if (p < 32) p = 32;
    return p;
  endfunction

  task automatic model_edge(input bit r, input bit tv, input int t);
    int tg;
    int ns;
    int nsp;
    if (r) begin
      m_st = 0; m_tq = 0; m_seen = 0; m_sp = 0; m_cyc = 0;
      return;
    end
    tg  = m_target(m_st, m_tq);
    nsp = m_sp;
    if (m_cyc % 4 == 3) begin
      if (m_sp < tg) nsp = (m_sp + 16 > tg) ? tg : m_sp + 16;
      else if (m_sp > tg) nsp = (m_sp - 16 < tg) ? tg : m_sp - 16;
    end
    ns = m_st;
    if (m_seen != 0) begin
      if (m_st == 0) begin
        if (m_tq >= 35) ns = 1;
        else if (m_tq <= 15 && m_sp == 0) ns = 2;
      end else if (m_st == 1) begin
        if (m_tq <= 25) ns = 0;
      end else begin
        if (m_tq >= 20) ns = 0;
      end
    end
    if (tv) begin
      m_tq = t;
      m_seen = 1;
    end
    m_st = ns;
    m_sp = nsp;
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit tv, input int t);
    rst        = r;
    temp_valid = tv;
    temp       = 8'(t);
    @(posedge clk);
    model_edge(r, tv, t);
    #1;
    chk("m_state", int'(state), m_st);
    chk("m_speed", int'(speed), m_sp);
    chk("m_cooler", int'(cooler_on), int'(m_st == 1));
    chk("m_heater", int'(heater_on), int'(m_st == 2));
  endtask

  task automatic wait_speed(input string nm, input int want, input int budget);
    int n;
    n = 0;
    while (int'(speed) != want && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    chk(nm, int'(speed), want);
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    temp_valid = 0;
    temp = 0;
    m_st = 0; m_tq = 0; m_seen = 0; m_sp = 0; m_cyc = 0;

    vt[0]  = '{1, 0,  0, 0,  0, 0, 0};
    vt[1]  = '{0, 1, 40, 0,  0, 0, 0};
    vt[2]  = '{0, 0,  0, 1,  0, 1, 0};
    vt[3]  = '{0, 0,  0, 1,  0, 1, 0};
    vt[4]  = '{0, 0,  0, 1, 16, 1, 0};
    vt[5]  = '{0, 0,  0, 1, 16, 1, 0};
    vt[6]  = '{0, 0,  0, 1, 16, 1, 0};
    vt[7]  = '{0, 0,  0, 1, 16, 1, 0};
    vt[8]  = '{0, 0,  0, 1, 32, 1, 0};
    vt[9]  = '{0, 0,  0, 1, 32, 1, 0};
    vt[10] = '{0, 0,  0, 1, 32, 1, 0};
    vt[11] = '{0, 0,  0, 1, 32, 1, 0};

    // idle soak: seen=0 must block heating on temp_q=0
    step(1, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0);
    chk("soak_state", int'(state), 0);
    chk("soak_speed", int'(speed), 0);
    chk("soak_heater", int'(heater_on), 0);

    for (int i = 0; i < 12; i++) begin
      step(vt[i].r, vt[i].tv, vt[i].t);
      chk("tbl_state", int'(state), vt[i].st);
      chk("tbl_speed", int'(speed), vt[i].sp);
      chk("tbl_cooler", int'(cooler_on), int'(vt[i].co));
      chk("tbl_heater", int'(heater_on), int'(vt[i].he));
    end

    wait_speed("cool_120", 120, 100);
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("cool_hold", int'(speed), 120);

    step(0, 1, 60);
    wait_speed("cool_sat", 255, 100);
    step(0, 1, 26);
    wait_speed("cool_floor", 32, 100);
    chk("cool_floor_st", int'(state), 1);

    step(0, 1, 40);
    wait_speed("cool_back", 120, 100);
    step(0, 1, 30);
    wait_speed("hyst_40", 40, 100);
    chk("hyst_state", int'(state), 1);
    step(0, 1, 20);
    step(0, 0, 0);
    chk("leave_cool_st", int'(state), 0);
    chk("leave_cool_co", int'(cooler_on), 0);
    wait_speed("decay_0", 0, 100);

    step(0, 1, 40);
    wait_speed("recool", 120, 100);
    step(0, 1, 10);
    step(0, 0, 0);
    chk("interlock_st", int'(state), 0);
    n = 0;
    while (int'(state) != 2 && n < 100) begin
      chk("interlock_he", int'(heater_on), 0);
      step(0, 0, 0);
      n++;
    end
    chk("heat_entered", int'(state), 2);
    chk("heat_on", int'(heater_on), 1);
    wait_speed("heat_80", 80, 100);
    step(0, 1, 12);
    wait_speed("heat_64", 64, 100);

    step(1, 0, 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_heater", int'(heater_on), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("post_rst_st", int'(state), 0);

    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit tv;
      int t;
      r  = ($urandom_range(0, 299) == 0);
      tv = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) t = $urandom_range(0, 255);
      else t = $urandom_range(5, 50);
      step(r, tv, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
